// File: rtl/io_input_conditioner_pkg.sv
// Shared board widths, clock rate and debounce defaults for the KEY/SW input front end.
// Also holds the per-bit flip classification used by the debouncer.
package io_input_conditioner_pkg;

    localparam int IO_N_KEY           = 4;
    localparam int IO_N_SW            = 10;
    localparam int IO_CLOCK_HZ        = 50_000_000;
    localparam int IO_DEBOUNCE_MS     = 10;
    localparam int IO_DEBOUNCE_CYCLES = (IO_CLOCK_HZ / 1000) * IO_DEBOUNCE_MS;

    typedef enum logic [1:0] {
        FLIP_NONE = 2'd0,
        FLIP_RISE = 2'd1,
        FLIP_FALL = 2'd2
    } flip_e;

    // Counter must be able to hold DEBOUNCE_CYCLES-1; one extra state keeps width >= 1.
    function automatic int dbnc_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One debounced input bit: two-flop synchroniser, stability counter, debounced level,
// and registered rise/fall pulses that coincide with the first cycle of the new level.
module debounce_bit
    import io_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
    parameter bit RESET_PIN       = 1'b0,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_d_o
);

    localparam int             CW     = dbnc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          sample;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          fall_q;
    flip_e         flip_d;

    assign sample = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip_d  = FLIP_NONE;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            level_d = sample;
            cnt_d   = '0;
            flip_d  = sample ? FLIP_RISE : FLIP_FALL;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_PIN;
            sync2_q <= RESET_PIN;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= (flip_d == FLIP_RISE);
            fall_q  <= (flip_d == FLIP_FALL);
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign rise_d_o = (flip_d == FLIP_RISE);

endmodule

// File: rtl/io_input_conditioner.sv
// Board KEY/SW front end: per-bit synchronise + debounce, active-high key levels,
// press/release pulses and write-1-to-clear sticky press flags for the I/O hub.
module io_input_conditioner
    import io_input_conditioner_pkg::*;
#(
    parameter int N_KEY           = IO_N_KEY,
    parameter int N_SW            = IO_N_SW,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_KEY-1:0] key_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_KEY-1:0] key_level,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_KEY-1:0] key_sticky,
    input  logic [N_KEY-1:0] sticky_clr
);

    logic [N_KEY-1:0] key_press_d;
    logic [N_KEY-1:0] key_sticky_q;
    logic [N_KEY-1:0] key_sticky_d;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_SW-1:0]  sw_fall_unused;
    logic [N_SW-1:0]  sw_rise_d_unused;

    // Key pins idle high (released) and are inverted so level 1 means pressed.
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_PIN       (1'b1),
            .ACTIVE_LOW      (1'b1)
        ) u_dbnc (
            .clock    (clock),
            .reset    (reset),
            .pin_i    (key_raw[k]),
            .level_o  (key_level[k]),
            .rise_o   (key_press[k]),
            .fall_o   (key_release[k]),
            .rise_d_o (key_press_d[k])
        );
    end

    for (genvar s = 0; s < N_SW; s++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_PIN       (1'b0),
            .ACTIVE_LOW      (1'b0)
        ) u_dbnc (
            .clock    (clock),
            .reset    (reset),
            .pin_i    (sw_raw[s]),
            .level_o  (sw_level[s]),
            .rise_o   (sw_rise_unused[s]),
            .fall_o   (sw_fall_unused[s]),
            .rise_d_o (sw_rise_d_unused[s])
        );
    end

    // A press landing on the same edge as a clear wins, so no press is ever lost.
    always_comb begin
        key_sticky_d = (key_sticky_q & ~sticky_clr) | key_press_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sticky_q <= '0;
        end else begin
            key_sticky_q <= key_sticky_d;
        end
    end

    assign key_sticky = key_sticky_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios with literal expectations, then
// randomized pins/clears/resets, all checked every cycle against a behavioural model.
module tb_io_input_conditioner;

    localparam int D  = 4;
    localparam int NK = 4;
    localparam int NS = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] sticky_clr;
    logic [NK-1:0] key_level;
    logic [NS-1:0] sw_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_sticky;

    io_input_conditioner #(
        .N_KEY           (NK),
        .N_SW            (NS),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_raw     (key_raw),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .sw_level    (sw_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_sticky  (key_sticky),
        .sticky_clr  (sticky_clr)
    );

    always #5 clock = ~clock;

    // Model: pins pass a two-edge synchroniser; a debounced level adopts the sample
    // once the sample has disagreed with it on D consecutive edges.
    logic [NK-1:0] mk1, mk2, mklvl, mkp, mkr, mstk;
    logic [NS-1:0] ms1, ms2, mslvl;
    int            krun [NK];
    int            srun [NS];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mk1 = '1; mk2 = '1; mklvl = '0; mkp = '0; mkr = '0; mstk = '0;
        ms1 = '0; ms2 = '0; mslvl = '0;
        for (int i = 0; i < NK; i++) krun[i] = 0;
        for (int i = 0; i < NS; i++) srun[i] = 0;
    endtask

    task automatic model_step();
        logic s;
        mkp = '0;
        mkr = '0;
        for (int i = 0; i < NK; i++) begin
            s = ~mk2[i];
            if (s == mklvl[i]) krun[i] = 0;
            else if (krun[i] == D - 1) begin
                mklvl[i] = s;
                krun[i]  = 0;
                if (s) mkp[i] = 1'b1;
                else   mkr[i] = 1'b1;
            end else krun[i]++;
        end
        for (int i = 0; i < NS; i++) begin
            s = ms2[i];
            if (s == mslvl[i]) srun[i] = 0;
            else if (srun[i] == D - 1) begin
                mslvl[i] = s;
                srun[i]  = 0;
            end else srun[i]++;
        end
        mstk = (mstk & ~sticky_clr) | mkp;
        mk2 = mk1; mk1 = key_raw;
        ms2 = ms1; ms1 = sw_raw;
    endtask

    task automatic compare_all();
        chk("key_level",   32'(key_level),   32'(mklvl));
        chk("sw_level",    32'(sw_level),    32'(mslvl));
        chk("key_press",   32'(key_press),   32'(mkp));
        chk("key_release", 32'(key_release), 32'(mkr));
        chk("key_sticky",  32'(key_sticky),  32'(mstk));
    endtask

    // Inputs change only at the falling edge; outputs are checked at the falling edge.
    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (hold) tick();
        @(negedge clock);
        reset = 1'b0;
    endtask

    int            hold_k [NK];
    int            hold_s [NS];
    logic [31:0]   seen;

    initial begin
        reset      = 1'b1;
        key_raw    = '1;
        sw_raw     = '0;
        sticky_clr = '0;
        model_reset();
        @(negedge clock);
        compare_all();
        chk("reset_outputs", 32'({key_level, sw_level, key_press, key_release, key_sticky}), 0);
        tick(); tick();
        reset = 1'b0;

        // 1: idle after reset
        seen = 0;
        repeat (20) begin
            tick();
            seen = seen | 32'({key_level, sw_level, key_press, key_release, key_sticky});
        end
        chk("t1_idle", seen, 0);

        // 2: key0 press and release, latency D+2 edges
        key_raw[0] = 1'b0;
        repeat (5) tick();
        chk("t2_lvl_e5", 32'(key_level[0]), 0);
        tick();
        chk("t2_lvl_e6",    32'(key_level[0]),  1);
        chk("t2_press_e6",  32'(key_press[0]),  1);
        chk("t2_sticky_e6", 32'(key_sticky[0]), 1);
        tick();
        chk("t2_press_e7", 32'(key_press[0]), 0);
        key_raw[0] = 1'b1;
        repeat (5) tick();
        chk("t2_rel_e5", 32'(key_release[0]), 0);
        tick();
        chk("t2_rel_e6",    32'(key_release[0]), 1);
        chk("t2_rel_lvl",   32'(key_level[0]),   0);
        chk("t2_rel_stick", 32'(key_sticky[0]),  1);
        tick();

        // 3: short glitch on key2
        key_raw[2] = 1'b0;
        repeat (3) tick();
        key_raw[2] = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            seen = seen | 32'({key_level[2], key_press[2], key_release[2], key_sticky[2]});
        end
        chk("t3_glitch", seen, 0);

        // 4: sticky clear, then clear racing a new press
        key_raw[1] = 1'b0;
        repeat (6) tick();
        chk("t4_set", 32'(key_sticky), 32'h3);
        key_raw[1] = 1'b1;
        repeat (8) tick();
        sticky_clr = 4'b0010;
        tick();
        sticky_clr = '0;
        chk("t4_clr", 32'(key_sticky), 32'h1);
        key_raw[1] = 1'b0;
        repeat (5) tick();
        sticky_clr = 4'b0010;
        tick();
        sticky_clr = '0;
        chk("t4_race_sticky", 32'(key_sticky[1]), 1);
        chk("t4_race_press",  32'(key_press[1]),  1);
        key_raw[1] = 1'b1;
        repeat (8) tick();

        // 5: switches
        sw_raw = 10'h2A5;
        repeat (5) tick();
        chk("t5_sw_e5", 32'(sw_level), 0);
        tick();
        chk("t5_sw_e6", 32'(sw_level), 32'h2A5);
        chk("t5_no_key", 32'({key_level, key_press, key_release}), 0);
        tick();

        // 6: reset mid-count on key3, key held through reset
        key_raw[3] = 1'b0;
        repeat (4) tick();
        do_reset(2);
        chk("t6_rst", 32'({key_level, sw_level, key_press, key_release, key_sticky}), 0);
        repeat (5) tick();
        chk("t6_press_e5", 32'(key_press[3]), 0);
        tick();
        chk("t6_press_e6", 32'(key_press[3]), 1);
        chk("t6_lvl_e6",   32'(key_level[3]), 1);
        key_raw[3] = 1'b1;
        repeat (8) tick();

        // randomized phase
        for (int i = 0; i < NK; i++) hold_k[i] = 0;
        for (int i = 0; i < NS; i++) hold_s[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold_k[i] == 0) begin
                    key_raw[i] = 1'($urandom_range(0, 1));
                    hold_k[i]  = $urandom_range(1, 9);
                end else hold_k[i]--;
            end
            for (int i = 0; i < NS; i++) begin
                if (hold_s[i] == 0) begin
                    sw_raw[i] = 1'($urandom_range(0, 1));
                    hold_s[i] = $urandom_range(1, 12);
                end else hold_s[i]--;
            end
            sticky_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 2));
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
